// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct values, ALU/operand/PC-source encodings and the per-state
// datapath control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StAluWb,
    StBranch,
    StAddiEx,
    StAddiWb,
    StJump
  } state_e;

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type funct field, instruction bits [5:0]
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // alu_control encodings
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALU B operand select
  localparam logic [1:0] SrcbReg    = 2'b00;
  localparam logic [1:0] SrcbFour   = 2'b01;
  localparam logic [1:0] SrcbImm    = 2'b10;
  localparam logic [1:0] SrcbImmSh2 = 2'b11;

  // PC source select
  localparam logic [1:0] PcsrcAlu    = 2'b00;
  localparam logic [1:0] PcsrcAluOut = 2'b01;
  localparam logic [1:0] PcsrcJump   = 2'b10;

  // How alu_control is chosen: fixed add, fixed sub, or decoded from funct
  typedef enum logic [1:0] {
    AluModeAdd,
    AluModeSub,
    AluModeFunct
  } alu_mode_e;

  // Moore part of the control word; fetch/branch/jump mark states whose
  // irwrite/pc_en also depend on mem_ready or zero.
  typedef struct packed {
    logic      mem_req;
    logic      iord;
    logic      alusrca;
    logic      regdst;
    logic      memtoreg;
    logic      regwrite;
    logic      memwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    alu_mode_e alu_mode;
    logic      fetch;
    logic      branch;
    logic      jump;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e st);
    ctrl_t c;
    c = '0;
    c.alu_mode = AluModeAdd;
    case (st)
      StFetch: begin
        c.mem_req = 1'b1;
        c.alusrcb = SrcbFour;
        c.pcsrc   = PcsrcAlu;
        c.fetch   = 1'b1;
      end
      StDecode: c.alusrcb = SrcbImmSh2;
      StMemAdr: begin
        c.alusrca = 1'b1;
        c.alusrcb = SrcbImm;
      end
      StMemRd: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      StMemWb: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      StMemWr: begin
        c.mem_req  = 1'b1;
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      StExec: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = SrcbReg;
        c.alu_mode = AluModeFunct;
      end
      StAluWb: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      StBranch: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = SrcbReg;
        c.pcsrc    = PcsrcAluOut;
        c.alu_mode = AluModeSub;
        c.branch   = 1'b1;
      end
      StAddiEx: begin
        c.alusrca = 1'b1;
        c.alusrcb = SrcbImm;
      end
      StAddiWb: c.regwrite = 1'b1;
      StJump: begin
        c.pcsrc = PcsrcJump;
        c.jump  = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit bus: instruction fields and status in, datapath controls out.
// master drives the instruction/status side, slave is the control unit.
interface multicycle_control_if #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ALUCTL_W = 3
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                iord;
  logic                irwrite;
  logic                alusrca;
  logic                regdst;
  logic                memtoreg;
  logic                regwrite;
  logic                memwrite;
  logic [1:0]          alusrcb;
  logic [1:0]          pcsrc;
  logic                pc_en;
  logic [ALUCTL_W-1:0] alu_control;
  logic                illegal;
  logic [CNT_W-1:0]    retired;

  modport master (
    output opcode, funct, zero, mem_ready,
    input  mem_req, iord, irwrite, alusrca, regdst, memtoreg, regwrite, memwrite,
    input  alusrcb, pcsrc, pc_en, alu_control, illegal, retired
  );

  modport slave (
    input  opcode, funct, zero, mem_ready,
    output mem_req, iord, irwrite, alusrca, regdst, memtoreg, regwrite, memwrite,
    output alusrcb, pcsrc, pc_en, alu_control, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_alu_funct_decode.sv
// ALU operation decode: maps the state-selected ALU mode and the funct field
// to alu_control, flagging funct values with no defined operation.
module alu_funct_decode
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTL_W = 3
) (
  input  alu_mode_e           mode,
  input  logic [5:0]          funct,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                funct_illegal
);

  logic [2:0] code;

  // Select the ALU operation; unknown funct falls back to add
  always_comb begin
    code          = AluAdd;
    funct_illegal = 1'b0;
    case (mode)
      AluModeSub: code = AluSub;
      AluModeFunct: begin
        case (funct)
          FnAdd:   code = AluAdd;
          FnSub:   code = AluSub;
          FnAnd:   code = AluAnd;
          FnOr:    code = AluOr;
          FnSlt:   code = AluSlt;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  assign alu_control = ALUCTL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit. Moore controls are registered alongside the
// state (ctrl_q always equals state_ctrl(state_q)); irwrite/pc_en add the
// same-cycle mem_ready/zero terms. Build option MULTICYCLE_BNE_EN adds bne.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ALUCTL_W = 3
) (
  input logic                clk,
  input logic                reset_n,
  multicycle_control_if.slave bus
);

  state_e              state_q, state_d;
  ctrl_t               ctrl_q;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    retired_q;
  logic                retire;
  logic                funct_illegal;
  logic                branch_take;
  logic [ALUCTL_W-1:0] alu_control;

  alu_funct_decode #(
    .ALUCTL_W(ALUCTL_W)
  ) u_alu_funct_decode (
    .mode         (ctrl_q.alu_mode),
    .funct        (bus.funct),
    .alu_control  (alu_control),
    .funct_illegal(funct_illegal)
  );

  // Next state, sticky illegal update and instruction-retire strobe
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      StFetch: if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
`ifdef MULTICYCLE_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = (bus.opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (bus.mem_ready) state_d = StMemWb;
      StMemWr: begin
        if (bus.mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec: begin
        state_d = StAluWb;
        if (funct_illegal) illegal_d = 1'b1;
      end
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StAddiWb, StBranch, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // Branch condition; opcode is held in the instruction register through BRANCH
  always_comb begin
`ifdef MULTICYCLE_BNE_EN
    branch_take = (bus.opcode == OpBne) ? ~bus.zero : bus.zero;
`else
    branch_take = bus.zero;
`endif
  end

  // FSM state, registered control word, sticky flag and retire counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      ctrl_q    <= state_ctrl(StFetch);
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= state_ctrl(state_d);
      illegal_q <= illegal_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.mem_req     = ctrl_q.mem_req;
  assign bus.iord        = ctrl_q.iord;
  assign bus.alusrca     = ctrl_q.alusrca;
  assign bus.regdst      = ctrl_q.regdst;
  assign bus.memtoreg    = ctrl_q.memtoreg;
  assign bus.regwrite    = ctrl_q.regwrite;
  assign bus.memwrite    = ctrl_q.memwrite;
  assign bus.alusrcb     = ctrl_q.alusrcb;
  assign bus.pcsrc       = ctrl_q.pcsrc;
  assign bus.irwrite     = ctrl_q.fetch & bus.mem_ready;
  assign bus.pc_en       = (ctrl_q.fetch & bus.mem_ready) | ctrl_q.jump |
                           (ctrl_q.branch & branch_take);
  assign bus.alu_control = alu_control;
  assign bus.illegal     = illegal_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class state by
// state against hand-computed control words, plus stall, reset and wrap cases.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(16), .ALUCTL_W(3)) bus ();
  multicycle_control_if #(.CNT_W(4),  .ALUCTL_W(3)) bus_w ();

  multicycle_control #(.CNT_W(16), .ALUCTL_W(3)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Narrow counter instance so the wrap is reachable in a short run
  multicycle_control #(.CNT_W(4), .ALUCTL_W(3)) dut_w (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_w)
  );

  int checks = 0;
  int errors = 0;

  // {mem_req,iord,irwrite,alusrca,regdst,memtoreg,regwrite,memwrite,alusrcb,pcsrc,pc_en,alu}
  logic [15:0] ctl;
  assign ctl = {bus.mem_req, bus.iord, bus.irwrite, bus.alusrca, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.memwrite, bus.alusrcb, bus.pcsrc, bus.pc_en, bus.alu_control};

  function automatic logic [15:0] pk(input logic [7:0] flags, input logic [1:0] srcb,
                                     input logic [1:0] pcs, input logic pce,
                                     input logic [2:0] alu);
    return {flags, srcb, pcs, pce, alu};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = rdy;
    #1;
  endtask

  logic [15:0] e_fetch, e_fetch_r, e_decode, e_memadr, e_memrd, e_memwb, e_memwr;
  logic [15:0] e_aluwb, e_addiex, e_addiwb, e_jump;
  logic [5:0]  fns  [5];
  logic [2:0]  alus [5];

  initial begin
    e_fetch   = pk(8'b1000_0000, 2'b01, 2'b00, 1'b0, 3'b010);
    e_fetch_r = pk(8'b1010_0000, 2'b01, 2'b00, 1'b1, 3'b010);
    e_decode  = pk(8'b0000_0000, 2'b11, 2'b00, 1'b0, 3'b010);
    e_memadr  = pk(8'b0001_0000, 2'b10, 2'b00, 1'b0, 3'b010);
    e_memrd   = pk(8'b1100_0000, 2'b00, 2'b00, 1'b0, 3'b010);
    e_memwb   = pk(8'b0000_0110, 2'b00, 2'b00, 1'b0, 3'b010);
    e_memwr   = pk(8'b1100_0001, 2'b00, 2'b00, 1'b0, 3'b010);
    e_aluwb   = pk(8'b0000_1010, 2'b00, 2'b00, 1'b0, 3'b010);
    e_addiex  = pk(8'b0001_0000, 2'b10, 2'b00, 1'b0, 3'b010);
    e_addiwb  = pk(8'b0000_0010, 2'b00, 2'b00, 1'b0, 3'b010);
    e_jump    = pk(8'b0000_0000, 2'b00, 2'b10, 1'b1, 3'b010);
    fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    alus = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    reset_n         = 1'b0;
    bus_w.opcode    = 6'b000010;
    bus_w.funct     = 6'b0;
    bus_w.zero      = 1'b0;
    bus_w.mem_ready = 1'b0;
    drive(6'b0, 6'b0, 1'b0, 1'b0);
    repeat (2) cyc();
    chk("rst_retired", 32'(bus.retired), 0);
    chk("rst_illegal", 32'(bus.illegal), 0);
    chk("rst_ctl", 32'(ctl), 32'(e_fetch));

    reset_n = 1'b1;
    #1;
    chk("first_mem_req", 32'(bus.mem_req), 1);
    cyc();
    chk("fetch_stall", 32'(ctl), 32'(e_fetch));

    // lw, memory always ready
    drive(6'b100011, 6'b0, 1'b0, 1'b1);
    chk("lw_fetch", 32'(ctl), 32'(e_fetch_r));
    cyc(); chk("lw_decode", 32'(ctl), 32'(e_decode));
    cyc(); chk("lw_memadr", 32'(ctl), 32'(e_memadr));
    cyc(); chk("lw_memrd", 32'(ctl), 32'(e_memrd));
    cyc(); chk("lw_memwb", 32'(ctl), 32'(e_memwb));
    chk("lw_ret_hold", 32'(bus.retired), 0);
    cyc(); chk("lw_ret", 32'(bus.retired), 1);
    chk("lw_fetch_again", 32'(ctl), 32'(e_fetch_r));

    // sw with three not-ready cycles in MEMWR
    drive(6'b101011, 6'b0, 1'b0, 1'b1);
    cyc(); chk("sw_decode", 32'(ctl), 32'(e_decode));
    cyc(); chk("sw_memadr", 32'(ctl), 32'(e_memadr));
    cyc(); drive(6'b101011, 6'b0, 1'b0, 1'b0);
    chk("sw_memwr0", 32'(ctl), 32'(e_memwr));
    for (int i = 1; i < 3; i++) begin
      cyc(); chk("sw_stall", 32'(ctl), 32'(e_memwr));
    end
    cyc(); drive(6'b101011, 6'b0, 1'b0, 1'b1);
    chk("sw_memwr_rdy", 32'(ctl), 32'(e_memwr));
    chk("sw_ret_hold", 32'(bus.retired), 1);
    cyc(); chk("sw_ret", 32'(bus.retired), 2);
    chk("sw_fetch", 32'(ctl), 32'(e_fetch_r));

    // R-type across every defined funct
    for (int k = 0; k < 5; k++) begin
      drive(6'b000000, fns[k], 1'b0, 1'b1);
      cyc(); cyc();
      chk("rtype_exec", 32'(ctl), 32'(pk(8'b0001_0000, 2'b00, 2'b00, 1'b0, alus[k])));
      cyc(); chk("rtype_aluwb", 32'(ctl), 32'(e_aluwb));
      cyc(); chk("rtype_ret", 32'(bus.retired), 32'(3 + k));
    end
    chk("rtype_no_illegal", 32'(bus.illegal), 0);

    // beq taken then not taken
    drive(6'b000100, 6'b0, 1'b1, 1'b1);
    cyc(); chk("beq_decode", 32'(ctl), 32'(e_decode));
    cyc(); chk("beq_taken", 32'(ctl), 32'(pk(8'b0001_0000, 2'b00, 2'b01, 1'b1, 3'b110)));
    cyc(); chk("beq_ret", 32'(bus.retired), 8);
    drive(6'b000100, 6'b0, 1'b0, 1'b1);
    cyc(); cyc();
    chk("beq_not_taken", 32'(ctl), 32'(pk(8'b0001_0000, 2'b00, 2'b01, 1'b0, 3'b110)));
    cyc(); chk("beq_nt_ret", 32'(bus.retired), 9);
    chk("beq_nt_fetch", 32'(ctl), 32'(e_fetch_r));

    // addi and j
    drive(6'b001000, 6'b0, 1'b0, 1'b1);
    cyc(); cyc(); chk("addi_ex", 32'(ctl), 32'(e_addiex));
    cyc(); chk("addi_wb", 32'(ctl), 32'(e_addiwb));
    cyc(); chk("addi_ret", 32'(bus.retired), 10);
    drive(6'b000010, 6'b0, 1'b0, 1'b1);
    cyc(); cyc(); chk("j_jump", 32'(ctl), 32'(e_jump));
    cyc(); chk("j_ret", 32'(bus.retired), 11);

    // Undefined funct: add, sticky illegal
    drive(6'b000000, 6'b000000, 1'b0, 1'b1);
    cyc(); cyc();
    chk("badfn_alu", 32'(ctl), 32'(pk(8'b0001_0000, 2'b00, 2'b00, 1'b0, 3'b010)));
    chk("badfn_pre", 32'(bus.illegal), 0);
    cyc(); chk("badfn_illegal", 32'(bus.illegal), 1);
    cyc();
    reset_n = 1'b0;
    #1;
    chk("rst_clears_illegal", 32'(bus.illegal), 0);
    chk("rst_clears_retired", 32'(bus.retired), 0);
    cyc();
    reset_n = 1'b1;

    // Undefined opcode after one retired j
    drive(6'b000010, 6'b0, 1'b0, 1'b1);
    cyc(); cyc(); cyc();
    chk("j2_ret", 32'(bus.retired), 1);
    drive(6'b111111, 6'b0, 1'b0, 1'b1);
    cyc(); chk("ill_decode", 32'(ctl), 32'(e_decode));
    chk("ill_pre", 32'(bus.illegal), 0);
    cyc(); chk("ill_flag", 32'(bus.illegal), 1);
    chk("ill_fetch", 32'(ctl), 32'(e_fetch_r));
    chk("ill_ret_hold", 32'(bus.retired), 1);

    // Reset during MEMWB drops the register write at once
    drive(6'b100011, 6'b0, 1'b0, 1'b1);
    cyc(); cyc(); cyc(); cyc();
    chk("abort_memwb", 32'(ctl), 32'(e_memwb));
    reset_n = 1'b0;
    drive(6'b100011, 6'b0, 1'b0, 1'b0);
    chk("abort_ctl", 32'(ctl), 32'(e_fetch));
    chk("abort_ret", 32'(bus.retired), 0);
    chk("abort_illegal", 32'(bus.illegal), 0);
    cyc();
    reset_n = 1'b1;
    #1;

    // bne: branch when the option is built, illegal otherwise
    drive(6'b000101, 6'b0, 1'b0, 1'b1);
    cyc(); cyc();
`ifdef MULTICYCLE_BNE_EN
    chk("bne_branch", 32'(ctl), 32'(pk(8'b0001_0000, 2'b00, 2'b01, 1'b1, 3'b110)));
    cyc(); chk("bne_ret", 32'(bus.retired), 1);
    chk("bne_legal", 32'(bus.illegal), 0);
`else
    chk("bne_fetch", 32'(ctl), 32'(e_fetch_r));
    chk("bne_illegal", 32'(bus.illegal), 1);
    chk("bne_ret_hold", 32'(bus.retired), 0);
`endif

    // Counter wrap on the narrow instance: 15 jumps, then the wrapping one
    bus_w.mem_ready = 1'b1;
    repeat (45) cyc();
    chk("wrap_pre", 32'(bus_w.retired), 15);
    cyc(); cyc();
    chk("wrap_jump", 32'({bus_w.pcsrc, bus_w.pc_en}), 32'(3'b101));
    cyc(); chk("wrap_ret", 32'(bus_w.retired), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
